a25_bus_arbiter: RTL and testbench
==================================

A25_BUS_ARBITER -- requirements
Module: a25_bus_arbiter

Interface
REQ-001 SHALL have parameter: BEATS, 4, number of 32-bit beats per line burst (fixed at 4; the 128-bit line requires it).
REQ-002 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: i_req0  in  1, i_addr0  in  32  fetch port, line read request and address.
REQ-005 SHALL have ports: o_ready0  out  1, o_rdata0  out  128  fetch completion pulse and line data.
REQ-006 SHALL have ports: i_req1 in 1, i_burst1 in 1, i_we1 in 1, i_addr1 in 32, i_wdata1 in 32, i_sel1 in 4  data port request.
REQ-007 SHALL have ports: o_ready1  out  1, o_rdata1  out  128  data completion pulse and data.
REQ-008 SHALL have ports: o_wb_cyc, o_wb_stb, o_wb_we  out  1 each; o_wb_adr out 32; o_wb_sel out 4; o_wb_dat out 32; i_wb_dat in 32; i_wb_ack in 1  Wishbone master.

Function
REQ-009 SHALL implement FSM states IDLE, BURST, SINGLE, DONE.
REQ-010 IDLE: the next state SHALL be BURST for a fetch, or a data request with i_burst1=1; SINGLE for a data request with i_burst1=0; otherwise IDLE.
REQ-011 When both ports request in IDLE, the grant SHALL go to the port not granted last; last-grant register resets to 0, so first contention grants port 1.
REQ-012 On grant, address, we, sel and wdata of the granted port SHALL be registered; o_wb_cyc=o_wb_stb=1 from the next cycle.
REQ-013 BURST: o_wb_adr SHALL equal {addr[31:4], beat[1:0], 2'b00}; beat starts at 0 regardless of addr[3:0]; o_wb_we=0, o_wb_sel=4'hF.
REQ-014 Each i_wb_ack in BURST SHALL store i_wb_dat into rdata[beat*32 +: 32] and increment beat; stb stays high between beats.
REQ-015 An ack on beat 3 SHALL move BURST to DONE and drop cyc/stb the next cycle.
REQ-016 SINGLE: one beat with registered addr (unaligned bits passed through), we, sel, wdata; the ack SHALL move SINGLE to DONE.
REQ-017 A SINGLE read SHALL return i_wb_dat in o_rdata1[31:0] with [127:32]=0; a SINGLE write SHALL leave rdata as zero.
REQ-018 DONE SHALL last one cycle with o_readyN=1 for the granted port only, then go to IDLE.
REQ-019 o_rdataN SHALL be stable and valid while o_readyN=1; it is undefined otherwise.
REQ-020 Requester rule: req and fields SHALL be held until the edge ending the ready cycle; req high in IDLE thereafter is a new transaction.
REQ-021 i_wb_ack SHALL be ignored in IDLE and DONE.
REQ-022 Wait states (ack low) SHALL hold the state, beat and all Wishbone outputs unchanged.
REQ-023 Minimum burst latency (zero-wait ack) SHALL be 6 cycles from req sampled in IDLE to o_ready; SINGLE minimum latency SHALL be 3 cycles.

Reset
REQ-024 Reset SHALL force IDLE, beat=0, last-grant=0, and all outputs to 0 (cyc, stb, we, adr, sel, dat, ready, rdata).
REQ-025 Reset mid-transaction SHALL drop cyc/stb the next cycle, discard partial data and issue no ready pulse.

Structure
REQ-026 Package a25_bus_arbiter_pkg SHALL hold the state enum, BEATS, and port index constants PORT_FETCH=0 and PORT_DATA=1.
REQ-027 Sub-module rr_pick2 SHALL hold the 2-way round-robin selection: inputs req[1:0] and last; outputs grant_valid and grant_idx.

Verification
REQ-028 Fetch req, addr 0x0000_1234, zero-wait acks -> wb adr 0x1230, 0x1234, 0x1238, 0x123C; o_ready0 one cycle; o_rdata0 = {d3,d2,d1,d0}.
REQ-029 Both req in the same cycle after reset -> data port served first, then fetch; alternate thereafter under continuous contention.
REQ-030 Data single write, addr 0x80, wdata 0xDEADBEEF, sel 4'b0011 -> one beat with we=1, sel=3; o_ready1 pulse; o_ready0 stays 0.
REQ-031 Burst with 2 wait cycles per beat -> wb outputs stable through waits; ready at cycle 14 after the grant cycle.
REQ-032 Reset asserted after beat 1 ack -> cyc=0 next cycle; no ready; next fetch restarts at beat 0.
REQ-033 Spurious ack in IDLE -> no state change, no ready, rdata unchanged.

Source files
------------

// File: rtl/a25_bus_arbiter_pkg.sv
// Shared types and constants for the two-port Wishbone line/beat arbiter.
package a25_bus_arbiter_pkg;

  localparam int BEATS = 4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    SINGLE,
    DONE
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the port not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  // NOTE: every output gets a default before the conditionals so no latch is inferred.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (&req) begin
      grant_idx = ~last;
    end else begin
      grant_idx = req[1];
    end
  end

endmodule

// File: rtl/a25_bus_arbiter.sv
// Arbitrates a fetch port (128-bit line bursts) and a data port (bursts or
// single beats) onto one Wishbone master.
module a25_bus_arbiter
  import a25_bus_arbiter_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         i_req0,
  input  logic [31:0]  i_addr0,
  output logic         o_ready0,
  output logic [127:0] o_rdata0,

  input  logic         i_req1,
  input  logic         i_burst1,
  input  logic         i_we1,
  input  logic [31:0]  i_addr1,
  input  logic [31:0]  i_wdata1,
  input  logic [3:0]   i_sel1,
  output logic         o_ready1,
  output logic [127:0] o_rdata1,

  output logic         o_wb_cyc,
  output logic         o_wb_stb,
  output logic         o_wb_we,
  output logic [31:0]  o_wb_adr,
  output logic [3:0]   o_wb_sel,
  output logic [31:0]  o_wb_dat,
  input  logic [31:0]  i_wb_dat,
  input  logic         i_wb_ack
);

  state_t        state_q, state_d;
  logic [1:0]    beat_q;
  logic          grant_q;     // port of the current (or most recent) grant
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [127:0]  rdata_q;

  logic          grant_valid;
  logic          grant_idx;
  logic          want_burst;

  rr_pick2 u_pick (
    .req         ({i_req1, i_req0}),
    .last        (grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign want_burst = (grant_idx == PORT_FETCH) || i_burst1;

  always_comb begin
    state_d  = state_q;
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_adr = '0;
    o_wb_sel = '0;
    o_wb_dat = '0;
    o_ready0 = 1'b0;
    o_ready1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = want_burst ? BURST : SINGLE;
      end
      BURST: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        // Bursts always start at beat 0 of the line, whatever addr[3:0] was.
        o_wb_adr = {addr_q[31:4], beat_q, 2'b00};
        o_wb_sel = 4'hF;
        if (i_wb_ack && (beat_q == 2'(BEATS - 1))) state_d = DONE;
      end
      SINGLE: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = we_q;
        o_wb_adr = addr_q;
        o_wb_sel = sel_q;
        o_wb_dat = wdata_q;
        if (i_wb_ack) state_d = DONE;
      end
      DONE: begin
        o_ready0 = (grant_q == PORT_FETCH);
        o_ready1 = (grant_q == PORT_DATA);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the line buffer is reset because rdata is a visible output that
      // must read zero after reset; it is flops, not a RAM.
      state_q <= IDLE;
      beat_q  <= '0;
      grant_q <= PORT_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            grant_q <= grant_idx;
            beat_q  <= '0;
            rdata_q <= '0;
            if (grant_idx == PORT_FETCH) begin
              addr_q  <= i_addr0;
              we_q    <= 1'b0;
              sel_q   <= 4'hF;
              wdata_q <= '0;
            end else begin
              addr_q  <= i_addr1;
              we_q    <= i_we1 & ~i_burst1;
              sel_q   <= i_sel1;
              wdata_q <= i_wdata1;
            end
          end
        end
        BURST: begin
          if (i_wb_ack) begin
            rdata_q[{beat_q, 5'd0} +: 32] <= i_wb_dat;
            beat_q <= beat_q + 2'd1;
          end
        end
        SINGLE: begin
          if (i_wb_ack && !we_q) rdata_q[31:0] <= i_wb_dat;
        end
        default: ;
      endcase
    end
  end

  assign o_rdata0 = rdata_q;
  assign o_rdata1 = rdata_q;

endmodule

// File: tb/tb_a25_bus_arbiter.sv
// Self-checking bench for a25_bus_arbiter: Wishbone slave model with
// programmable wait states, completion scoreboard and a table of transactions.
module tb_a25_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_req0 = 1'b0;
  logic [31:0]  i_addr0 = '0;
  logic         o_ready0;
  logic [127:0] o_rdata0;
  logic         i_req1 = 1'b0;
  logic         i_burst1 = 1'b0;
  logic         i_we1 = 1'b0;
  logic [31:0]  i_addr1 = '0;
  logic [31:0]  i_wdata1 = '0;
  logic [3:0]   i_sel1 = '0;
  logic         o_ready1;
  logic [127:0] o_rdata1;
  logic         o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0]  o_wb_adr;
  logic [3:0]   o_wb_sel;
  logic [31:0]  o_wb_dat;
  logic [31:0]  i_wb_dat = '0;
  logic         i_wb_ack = 1'b0;

  always #5 clk = ~clk;

  a25_bus_arbiter #(.BEATS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req0   (i_req0),
    .i_addr0  (i_addr0),
    .o_ready0 (o_ready0),
    .o_rdata0 (o_rdata0),
    .i_req1   (i_req1),
    .i_burst1 (i_burst1),
    .i_we1    (i_we1),
    .i_addr1  (i_addr1),
    .i_wdata1 (i_wdata1),
    .i_sel1   (i_sel1),
    .o_ready1 (o_ready1),
    .o_rdata1 (o_rdata1),
    .o_wb_cyc (o_wb_cyc),
    .o_wb_stb (o_wb_stb),
    .o_wb_we  (o_wb_we),
    .o_wb_adr (o_wb_adr),
    .o_wb_sel (o_wb_sel),
    .o_wb_dat (o_wb_dat),
    .i_wb_dat (i_wb_dat),
    .i_wb_ack (i_wb_ack)
  );

  typedef struct {
    logic         port;
    logic [127:0] rdata;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic        port;
    logic        burst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          waits;
    int          cycles;   // req-sampled cycle counted as cycle 1
    int          beats;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  exp_t  sb[$];
  beat_t beat_log[$];
  int    waits = 0;
  logic  spur = 1'b0;
  logic [127:0] last_exp_rdata = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'h5A5A_A5A5;
  endfunction

  // Wishbone slave: decides ack shortly after each edge, for sampling at the next one.
  int    slave_wc = 0;
  logic [68:0] slave_snap = '0;
  always begin
    logic [68:0] cur;
    beat_t bt;
    @(posedge clk);
    #2;
    if (o_wb_cyc && o_wb_stb) begin
      cur = {o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat};
      if (slave_wc == 0) slave_snap = cur;
      else check("wait_hold", 128'(cur), 128'(slave_snap));
      if (slave_wc < waits) begin
        i_wb_ack = 1'b0;
        slave_wc++;
      end else begin
        i_wb_ack = 1'b1;
        i_wb_dat = o_wb_we ? 32'h0 : mem_f(o_wb_adr);
        bt.adr = o_wb_adr; bt.we = o_wb_we; bt.sel = o_wb_sel; bt.dat = o_wb_dat;
        beat_log.push_back(bt);
        slave_wc = 0;
      end
    end else begin
      i_wb_ack = spur;
      i_wb_dat = spur ? 32'hFFFF_FFFF : 32'h0;
      slave_wc = 0;
    end
  end

  // Completion monitor: every ready pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (o_ready0 || o_ready1) begin
      if (sb.size() == 0) begin
        check("ready_unexpected", 128'({o_ready1, o_ready0}), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_port", 128'({o_ready1, o_ready0}), e.port ? 128'(2'b10) : 128'(2'b01));
        check("rdata", e.port ? o_rdata1 : o_rdata0, e.rdata);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    logic         is_burst;
    int           nb;
    logic [31:0]  eadr [4];
    logic [127:0] rd;
    exp_t         e;
    beat_t        bt;
    int           edges;
    logic         got;
    is_burst = (v.port == 1'b0) || v.burst;
    nb = is_burst ? 4 : 1;
    rd = '0;
    for (int b = 0; b < nb; b++) begin
      eadr[b] = is_burst ? {v.addr[31:4], 2'(b), 2'b00} : v.addr;
      if (is_burst) rd[b*32 +: 32] = mem_f(eadr[b]);
      else if (!v.we) rd[31:0] = mem_f(v.addr);
    end
    waits = v.waits;
    @(negedge clk);
    beat_log.delete();
    if (v.port == 1'b0) begin
      i_req0 = 1'b1; i_addr0 = v.addr;
    end else begin
      i_req1 = 1'b1; i_burst1 = v.burst; i_we1 = v.we;
      i_addr1 = v.addr; i_wdata1 = v.wdata; i_sel1 = v.sel;
    end
    e.port = v.port; e.rdata = rd;
    sb.push_back(e);
    last_exp_rdata = rd;
    edges = 0;
    got = 1'b0;
    while (edges < 40 && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      got = v.port ? o_ready1 : o_ready0;
    end
    check("latency", 128'(edges + 1), 128'(v.cycles));
    @(posedge clk);
    #1;
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    check("beat_count", 128'(beat_log.size()), 128'(v.beats));
    for (int i = 0; i < beat_log.size() && i < nb; i++) begin
      bt = beat_log[i];
      check("beat_adr_we_sel", 128'({bt.adr, bt.we, bt.sel}),
            128'({eadr[i], !is_burst && v.we, is_burst ? 4'hF : v.sel}));
      if (!is_burst && v.we) check("beat_wdata", 128'(bt.dat), 128'(v.wdata));
    end
  endtask

  vec_t vecs [6];

  initial begin
    exp_t e;
    int   n_done;
    int   budget;
    logic p;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0,         4'hF,   0,  6, 4};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'b0011, 0, 3, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_1003, 32'h0,         4'h1,   0,  3, 1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hABCD_EF08, 32'h0,         4'hF,   2, 14, 4};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h2000_0014, 32'h1111_2222, 4'h3,   1, 10, 4};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0,         4'hC,   3,  6, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb", 128'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat}), 128'(0));
    check("rst_ready", 128'({o_ready1, o_ready0}), 128'(0));
    check("rst_rdata0", o_rdata0, 128'(0));
    check("rst_rdata1", o_rdata1, 128'(0));
    reset = 1'b0;

    // Contention straight after reset: data, fetch, data, fetch.
    waits = 0;
    @(negedge clk);
    i_req0 = 1'b1; i_addr0 = 32'h0000_0500;
    i_req1 = 1'b1; i_burst1 = 1'b0; i_we1 = 1'b0; i_addr1 = 32'h0000_0900; i_sel1 = 4'hF;
    e.port = 1'b1; e.rdata = {96'h0, mem_f(32'h0000_0900)}; sb.push_back(e);
    e.port = 1'b0; e.rdata = {mem_f(32'h50C), mem_f(32'h508), mem_f(32'h504), mem_f(32'h500)}; sb.push_back(e);
    e.port = 1'b1; e.rdata = {96'h0, mem_f(32'h0000_0A04)}; sb.push_back(e);
    e.port = 1'b0; e.rdata = {mem_f(32'h61C), mem_f(32'h618), mem_f(32'h614), mem_f(32'h610)}; sb.push_back(e);
    n_done = 0;
    budget = 0;
    while (n_done < 4 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (o_ready0 || o_ready1) begin
        p = o_ready1;
        n_done++;
        @(posedge clk);
        #1;
        if (p) begin
          if (n_done < 3) i_addr1 = 32'h0000_0A04;
          else i_req1 = 1'b0;
        end else begin
          if (n_done < 4) i_addr0 = 32'h0000_061C;
          else i_req0 = 1'b0;
        end
      end
    end
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    check("contention_done", 128'(n_done), 128'(4));

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Spurious acks while idle must be ignored.
    @(negedge clk);
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_idle", 128'({o_wb_cyc, o_wb_stb, o_ready1, o_ready0}), 128'(0));
    end
    spur = 1'b0;
    check("spur_rdata", o_rdata1, last_exp_rdata);
    repeat (2) @(negedge clk);

    // Reset after the beat-1 ack of a fetch burst.
    waits = 0;
    i_req0 = 1'b1; i_addr0 = 32'h0000_3008;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    i_req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_cyc_stb", 128'({o_wb_cyc, o_wb_stb}), 128'(0));
    check("rst_mid_rdata", o_rdata0, 128'(0));
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_txn('{1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'h0, 4'hF, 0, 6, 4});

    repeat (4) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
